rgb_pll_ctrl: RTL and testbench

//  Sequences the RGB pixel-clock PLL. Holds it in reset at power-up, waits for lock with

---
 rtl/rgb_pll_pkg.sv | 19 +
 rtl/rgb_pll_ctrl_sync_2ff.sv | 25 ++
 rtl/rgb_pll_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_rgb_pll_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pll_pkg.sv
// Shared types and constants for the RGB pixel-clock PLL controller.
//   pll_state_t    : sequencing states of the controller FSM
//   PSDA_DEFAULT   : phase setting driven to the PLL out of reset
//   DUTYDA_DEFAULT : duty setting driven to the PLL out of reset
package rgb_pll_pkg;

    typedef enum logic [2:0] {
        RESET_HOLD,
        WAIT_LOCK,
        STABLE,
        RUN,
        SETTLE,
        FAULT
    } pll_state_t;

    localparam logic [3:0] PSDA_DEFAULT   = 4'b0000;
    localparam logic [3:0] DUTYDA_DEFAULT = 4'b1000;

endpackage

// File: rtl/rgb_pll_ctrl_sync_2ff.sv
// Two-flop synchronizer, used to bring the asynchronous PLL LOCK into the clk domain.
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset (both flops clear to 0)
//   d     in  asynchronous input
//   q     out synchronized output, two clk edges behind d
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rgb_pll_ctrl.sv
// RGB pixel-clock PLL sequencer.
// Holds the PLL in reset after power-up, waits for lock with a timeout and a bounded
// number of retries, qualifies lock as stable before raising ready, and applies
// run-time phase/duty changes through a valid/ready handshake.
//   clk          in   controller clock (free-running board clock)
//   rst_n        in   asynchronous active-low reset
//   pll_lock     in   PLL LOCK, asynchronous to clk
//   pll_reset    out  PLL RESET
//   pll_reset_p  out  PLL RESET_P (power-down), raised only on fault
//   pll_psda     out  PLL phase setting
//   pll_dutyda   out  PLL duty setting
//   cfg_valid    in   phase/duty change request
//   cfg_ready    out  request accepted when cfg_valid && cfg_ready
//   cfg_psda     in   requested phase setting
//   cfg_dutyda   in   requested duty setting
//   ready        out  PLL output usable by downstream video logic
//   fault        out  sticky: lock never achieved within the retry budget
//   retry_cnt    out  retries used in the current acquisition
module rgb_pll_ctrl
    import rgb_pll_pkg::*;
#(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int LOCK_STABLE   = 1024,
    parameter int SETTLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       pll_reset_p,
    output logic [3:0] pll_psda,
    output logic [3:0] pll_dutyda,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [3:0] cfg_psda,
    input  logic [3:0] cfg_dutyda,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_cnt
);

    // Terminal counts: each timed state leaves on the edge where the counter
    // holds its last value, so the state lasts exactly the parameter's cycles.
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

    pll_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lock_s;
    logic             pll_reset_nxt;
    logic             pll_reset_p_nxt;
    logic [3:0]       pll_psda_nxt;
    logic [3:0]       pll_dutyda_nxt;
    logic             ready_nxt;
    logic             fault_nxt;
    logic [1:0]       retry_cnt_nxt;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // Only a RUN-state request with lock still present can be taken; this also
    // rejects a request that coincides with lock loss.
    assign cfg_ready = (state == RUN) && lock_s;

    // State, shared counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RESET_HOLD;
            cnt         <= '0;
            pll_reset   <= 1'b1;
            pll_reset_p <= 1'b0;
            pll_psda    <= PSDA_DEFAULT;
            pll_dutyda  <= DUTYDA_DEFAULT;
            ready       <= 1'b0;
            fault       <= 1'b0;
            retry_cnt   <= 2'd0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            pll_reset   <= pll_reset_nxt;
            pll_reset_p <= pll_reset_p_nxt;
            pll_psda    <= pll_psda_nxt;
            pll_dutyda  <= pll_dutyda_nxt;
            ready       <= ready_nxt;
            fault       <= fault_nxt;
            retry_cnt   <= retry_cnt_nxt;
        end
    end

    // Next-state and next-output logic. Every transition clears the counter so
    // each state starts timing from zero and the counter never wraps.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        pll_reset_nxt   = pll_reset;
        pll_reset_p_nxt = pll_reset_p;
        pll_psda_nxt    = pll_psda;
        pll_dutyda_nxt  = pll_dutyda;
        ready_nxt       = ready;
        fault_nxt       = fault;
        retry_cnt_nxt   = retry_cnt;

        case (state)
            RESET_HOLD: begin
                pll_reset_nxt = 1'b1;
                ready_nxt     = 1'b0;
                if (cnt == RESET_LAST) begin
                    state_nxt     = WAIT_LOCK;
                    cnt_nxt       = '0;
                    pll_reset_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_nxt       = '0;
                    pll_reset_nxt = 1'b1;
                    if (retry_cnt == RETRY_LIMIT) begin
                        state_nxt       = FAULT;
                        pll_reset_p_nxt = 1'b1;
                        fault_nxt       = 1'b1;
                    end else begin
                        state_nxt     = RESET_HOLD;
                        retry_cnt_nxt = retry_cnt + 2'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            STABLE: begin
                // Any dropout restarts acquisition; the timeout path decides
                // whether the PLL itself needs another reset.
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt     = RUN;
                    cnt_nxt       = '0;
                    ready_nxt     = 1'b1;
                    retry_cnt_nxt = 2'd0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            RUN: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                    ready_nxt = 1'b0;
                end else if (cfg_valid && cfg_ready) begin
                    state_nxt      = SETTLE;
                    cnt_nxt        = '0;
                    pll_psda_nxt   = cfg_psda;
                    pll_dutyda_nxt = cfg_dutyda;
                    ready_nxt      = 1'b0;
                end
            end

            SETTLE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                    ready_nxt = 1'b0;
                end else if (cnt == SETTLE_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    ready_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            FAULT: begin
                // Terminal until rst_n: PLL held in reset and powered down.
                pll_reset_nxt   = 1'b1;
                pll_reset_p_nxt = 1'b1;
                ready_nxt       = 1'b0;
                fault_nxt       = 1'b1;
                cnt_nxt         = '0;
            end

            default: begin
                state_nxt     = RESET_HOLD;
                cnt_nxt       = '0;
                pll_reset_nxt = 1'b1;
                ready_nxt     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rgb_pll_ctrl.sv
// Scoreboard bench for rgb_pll_ctrl.
// Stimulus pushes the expected output vector, stamped with the clock cycle at which
// it must appear, into a queue. A monitor samples every falling edge and, whenever
// any output changes, pops the next entry and compares value and cycle.
// Vector layout: {pll_reset, pll_reset_p, ready, fault, cfg_ready, retry_cnt[1:0],
// pll_psda[3:0], pll_dutyda[3:0]}.
module tb_rgb_pll_ctrl;

    localparam int RESET_CYCLES  = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int LOCK_STABLE   = 8;
    localparam int SETTLE_CYCLES = 4;
    localparam int MAX_RETRIES   = 2;
    localparam int CNT_W         = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       pll_reset;
    logic       pll_reset_p;
    logic [3:0] pll_psda;
    logic [3:0] pll_dutyda;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_psda;
    logic [3:0] cfg_dutyda;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;

    typedef struct packed {
        int          cyc;
        logic [14:0] vec;
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [14:0] snap;
    logic [14:0] prev = 'x;

    rgb_pll_ctrl #(
        .RESET_CYCLES  (RESET_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .LOCK_STABLE   (LOCK_STABLE),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .pll_reset_p (pll_reset_p),
        .pll_psda    (pll_psda),
        .pll_dutyda  (pll_dutyda),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_psda    (cfg_psda),
        .cfg_dutyda  (cfg_dutyda),
        .ready       (ready),
        .fault       (fault),
        .retry_cnt   (retry_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [14:0] mk(logic rst, logic rstp, logic rdy, logic flt,
                                       logic cfr, logic [1:0] rc, logic [3:0] ps,
                                       logic [3:0] du);
        return {rst, rstp, rdy, flt, cfr, rc, ps, du};
    endfunction

    task automatic pushExpected(int at, string name, logic [14:0] v);
        exp_t e;
        e.cyc = at;
        e.vec = v;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic checkOutput(logic [14:0] actual);
        exp_t  e;
        string n;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_change: got %h at cycle %0d, want no change", actual, cyc);
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (actual !== e.vec || (e.cyc >= 0 && e.cyc != cyc)) begin
                errors++;
                $display("[TB] FAIL %s: got %h at cycle %0d, want %h at cycle %0d",
                         n, actual, cyc, e.vec, e.cyc);
            end
        end
    endtask

    task automatic checkNow(string name, logic [14:0] want);
        logic [14:0] actual;
        actual = {pll_reset, pll_reset_p, ready, fault, cfg_ready, retry_cnt, pll_psda, pll_dutyda};
        checks++;
        if (actual !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, want);
        end
    endtask

    task automatic applyStimulus(logic lock, logic valid, logic [3:0] ps, logic [3:0] du);
        pll_lock   = lock;
        cfg_valid  = valid;
        cfg_psda   = ps;
        cfg_dutyda = du;
    endtask

    task automatic waitNeg(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfgRequest(logic [3:0] ps, logic [3:0] du, string name);
        int t;
        t = cyc;
        applyStimulus(1'b1, 1'b1, ps, du);
        pushExpected(t + 1, {name, "_accept"}, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, ps, du));
        pushExpected(t + 5, {name, "_settled"}, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, ps, du));
        waitNeg(1);
        cfg_valid = 1'b0;
    endtask

    // Monitor: any change of the observed outputs must match the next expectation.
    always @(negedge clk) begin
        snap = {pll_reset, pll_reset_p, ready, fault, cfg_ready, retry_cnt, pll_psda, pll_dutyda};
        if (snap !== prev) checkOutput(snap);
        prev = snap;
    end

    initial begin
        int t;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        pushExpected(-1, "reset_values", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h8));
        waitNeg(3);

        // Power-up acquisition, lock arrives 10 cycles after reset release.
        $display("[TB] power-up acquisition");
        t = cyc;
        rst_n = 1'b1;
        pushExpected(t + 4, "reset_release", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h8));
        waitNeg(10);
        t = cyc;
        pll_lock = 1'b1;
        pushExpected(t + 11, "first_lock_ready", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'h0, 4'h8));
        waitNeg(14);

        // Phase/duty changes in RUN.
        $display("[TB] cfg handshakes");
        cfgRequest(4'h5, 4'h6, "cfg_5_6");
        waitNeg(6);
        cfgRequest(4'hA, 4'h3, "cfg_a_3");
        waitNeg(6);

        // Lock lost in the same cycle a request is presented: must be refused.
        $display("[TB] lock loss with request");
        t = cyc;
        pll_lock = 1'b0;
        pushExpected(t + 2, "loss_cfg_ready", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'hA, 4'h3));
        pushExpected(t + 3, "loss_ready", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'hA, 4'h3));
        waitNeg(2);
        applyStimulus(1'b0, 1'b1, 4'h9, 4'hC);
        waitNeg(1);
        cfg_valid = 1'b0;
        waitNeg(2);
        t = cyc;
        pll_lock = 1'b1;
        pushExpected(t + 11, "relock_run", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'hA, 4'h3));
        waitNeg(14);

        // Three-cycle dropout in the middle of the stable window.
        $display("[TB] dropout during stable qualification");
        t = cyc;
        pll_lock = 1'b0;
        pushExpected(t + 2, "drop_cfg_ready", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'hA, 4'h3));
        pushExpected(t + 3, "drop_ready", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'hA, 4'h3));
        waitNeg(5);
        pll_lock = 1'b1;
        waitNeg(6);
        pll_lock = 1'b0;
        waitNeg(3);
        t = cyc;
        pll_lock = 1'b1;
        pushExpected(t + 11, "glitch_relock_ready", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 4'hA, 4'h3));
        waitNeg(14);

        // Reset asserted while settling after a 5/6 change.
        $display("[TB] async reset during settle");
        t = cyc;
        applyStimulus(1'b1, 1'b1, 4'h5, 4'h6);
        pushExpected(t + 1, "settle_cfg_5_6", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h5, 4'h6));
        waitNeg(1);
        cfg_valid = 1'b0;
        waitNeg(1);
        t = cyc;
        #2;
        pushExpected(t + 1, "async_reset", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h8));
        rst_n = 1'b0;
        #1;
        checkNow("async_reset_now", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h8));
        waitNeg(1);
        pll_lock = 1'b0;
        waitNeg(2);

        // Lock never arrives: three reset pulses, then sticky fault.
        $display("[TB] retry and fault");
        t = cyc;
        rst_n = 1'b1;
        pushExpected(t + 4,   "try0_release", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h8));
        pushExpected(t + 36,  "retry1_reset", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'h0, 4'h8));
        pushExpected(t + 40,  "try1_release", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'h0, 4'h8));
        pushExpected(t + 72,  "retry2_reset", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'h0, 4'h8));
        pushExpected(t + 76,  "try2_release", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'h0, 4'h8));
        pushExpected(t + 108, "fault_entry",  mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 4'h0, 4'h8));
        waitNeg(115);
        pll_lock = 1'b1;
        waitNeg(20);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            while (exp_q.size() != 0) begin
                $display("[TB] FAIL missing_%s: got no change, want %h at cycle %0d",
                         name_q[0], exp_q[0].vec, exp_q[0].cyc);
                void'(exp_q.pop_front());
                void'(name_q.pop_front());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
